mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Synchronous scheduler for the shared memory read port. Arbitrates between instruction
//  fetch and data cache, issues one read at a time, and drives the dual-rail route select
//  PH0 of the memory-data demultiplexer.
//  Runs each transfer through a full four-phase NCL cycle (DATA -> ack -> NULL -> release)
//  before granting the next requester.
// PARAMETERS
//  ADDR_W      16   memory address width
//  SYNC_STAGES 2    flops in each ack synchroniser (>=2)
//  TIMEOUT     255  max cycles in WAIT_ACK/WAIT_REL before abort (8-bit counter)
// PORTS
//  clk        in   1       system clock, all logic on rising edge
//  rst        in   1       synchronous reset, active-high
//  i_req      in   1       fetch request, level, held until i_done
//  i_addr     in   ADDR_W  fetch address, stable while i_req
//  c_req      in   1       cache request, level, held until c_done
//  c_addr     in   ADDR_W  cache address, stable while c_req
//  mem_req    out  1       read strobe to memory, level until mem_rdy
//  mem_addr   out  ADDR_W  read address
//  mem_rdy    in   1       memory data valid on demux input, one-cycle pulse
//  ph0        out  2       dual-rail select {t,f}: 01=instr, 10=cache, 00=NULL; 11 never
//  hab_instr  in   1       async latch-enable/ack from demux instr side (synchronised here)
//  hab_cache  in   1       async latch-enable/ack from demux cache side (synchronised here)
//  i_done     out  1       1-cycle pulse, fetch transfer complete
//  c_done     out  1       1-cycle pulse, cache transfer complete
//  err_to     out  1       sticky timeout flag; cleared only by rst
// BEHAVIOUR
//  Reset: state=IDLE, mem_req=0, mem_addr=0, ph0=00, i_done=c_done=err_to=0,
//   last_grant=cache (fetch wins first tie), timeout counter=0, sync flops=0.
//  Outputs are registered. ph0 is one-hot or 00 in every cycle.
//  FSM:
//   IDLE     : grant on any req. Tie -> owner != last_grant (round robin).
//              Load mem_addr, set mem_req=1 -> MEM. Grant decision to mem_req=1: 1 cycle.
//   MEM      : hold mem_req/mem_addr. On mem_rdy: mem_req=0, ph0=owner code -> WAIT_ACK.
//   WAIT_ACK : hold ph0 until synced owner hab==1. Then ph0=00 -> WAIT_REL.
//   WAIT_REL : hold ph0=00 until synced owner hab==0.
//              Then pulse owner done, update last_grant -> IDLE.
//  Minimum transfer length: mem_rdy latency + 2*SYNC_STAGES + 3 cycles.
//  Only the owner's hab is monitored. The other hab is ignored and must not move the FSM.
//  Timeout:
//   - 8-bit counter cleared on entry to WAIT_ACK and to WAIT_REL.
//   - On reaching TIMEOUT: err_to=1, ph0=00, no done pulse, -> IDLE.
//   - The abandoned request stays pending and is re-arbitrated under normal round robin.
//  MEM has no timeout; memory is guaranteed to answer.
//  Req dropped after grant: the transfer completes anyway, and done still pulses.
//  Back-to-back: a done pulse and a new grant may never occur in the same cycle.
//   Earliest new mem_req is the cycle after done.
//  rst mid-transfer: immediate return to reset values.
//   ph0 forced 00 so the demux returns to NULL.
// STRUCTURE
//  Shared package mem_port_pkg:
//   - state enum {IDLE,MEM,WAIT_ACK,WAIT_REL}
//   - PH0_NULL=2'b00, PH0_INSTR=2'b01, PH0_CACHE=2'b10
//   - OWN_INSTR/OWN_CACHE
//  One sub-module: sync_ff (SYNC_STAGES-deep, rst-cleared), instantiated once per hab input.
//  Arbiter + FSM + counter in this module.
// TESTING
//  1. Fetch only, i_addr=16'h0040, mem_rdy 3 cycles after mem_req, hab model 2 cycles.
//     -> mem_addr=0040, ph0 01 then 00, single i_done, c_done=0.
//  2. i_req&c_req together from reset.
//     -> grant order instr, cache, instr, cache over 4 transfers; never ph0=11.
//  3. hab_cache stuck 0 during a cache transfer.
//     -> after 255 cycles in WAIT_ACK: err_to=1, ph0=00, no c_done.
//     -> next grant follows round robin (instr if pending).
//  4. hab_instr toggled while cache owns the port.
//     -> no state change; cache transfer completes with c_done.
//  5. rst asserted in WAIT_ACK with ph0=10.
//     -> next cycle ph0=00, mem_req=0, all done/err outputs 0, state IDLE.
//  6. i_req dropped in MEM.
//     -> transfer still completes and i_done pulses once; no spurious second grant.

Source files
------------

// File: rtl/mem_port_pkg.sv
// Shared types and codes for the memory read-port arbiter and its NCL demux handshake.
package mem_port_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MEM      = 2'd1,
        WAIT_ACK = 2'd2,
        WAIT_REL = 2'd3
    } state_t;

    typedef enum logic {
        OWN_INSTR = 1'b0,
        OWN_CACHE = 1'b1
    } owner_t;

    localparam logic [1:0] PH0_NULL  = 2'b00;
    localparam logic [1:0] PH0_INSTR = 2'b01;
    localparam logic [1:0] PH0_CACHE = 2'b10;

    // Dual-rail route code for a given owner; never yields 2'b11.
    function automatic logic [1:0] owner_code(input owner_t own);
        return (own == OWN_INSTR) ? PH0_INSTR : PH0_CACHE;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_sync_ff.sv
// Multi-flop synchroniser for an asynchronous handshake level, cleared by rst.
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk) begin
        if (rst) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin scheduler for the shared memory read port; sequences each transfer
// through a four-phase NCL handshake with the data demux before the next grant.
module mem_port_arbiter
    import mem_port_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              c_req,
    input  logic [ADDR_W-1:0] c_addr,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_rdy,
    output logic [1:0]        ph0,
    input  logic              hab_instr,
    input  logic              hab_cache,
    output logic              i_done,
    output logic              c_done,
    output logic              err_to
);

    state_t            state, state_n;
    owner_t            owner, owner_n;
    owner_t            last_grant, last_grant_n;
    logic [7:0]        cnt, cnt_n;
    logic              mem_req_n;
    logic [ADDR_W-1:0] mem_addr_n;
    logic [1:0]        ph0_n;
    logic              i_done_n, c_done_n, err_to_n;
    logic              hab_i_s, hab_c_s, owner_hab;
    logic              i_eff, c_eff, timed_out;

    sync_ff #(.STAGES(SYNC_STAGES)) u_sync_instr (
        .clk (clk),
        .rst (rst),
        .d   (hab_instr),
        .q   (hab_i_s)
    );

    sync_ff #(.STAGES(SYNC_STAGES)) u_sync_cache (
        .clk (clk),
        .rst (rst),
        .d   (hab_cache),
        .q   (hab_c_s)
    );

    // A requester whose done is pulsing this cycle still shows its old level; mask it
    // so the finished transfer is not granted a second time.
    assign i_eff     = i_req & ~i_done;
    assign c_eff     = c_req & ~c_done;
    assign owner_hab = (owner == OWN_INSTR) ? hab_i_s : hab_c_s;
    assign timed_out = (cnt == 8'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            owner      <= OWN_INSTR;
            last_grant <= OWN_CACHE;
            cnt        <= '0;
            mem_req    <= 1'b0;
            mem_addr   <= '0;
            ph0        <= PH0_NULL;
            i_done     <= 1'b0;
            c_done     <= 1'b0;
            err_to     <= 1'b0;
        end else begin
            state      <= state_n;
            owner      <= owner_n;
            last_grant <= last_grant_n;
            cnt        <= cnt_n;
            mem_req    <= mem_req_n;
            mem_addr   <= mem_addr_n;
            ph0        <= ph0_n;
            i_done     <= i_done_n;
            c_done     <= c_done_n;
            err_to     <= err_to_n;
        end
    end

    always_comb begin
        state_n      = state;
        owner_n      = owner;
        last_grant_n = last_grant;
        cnt_n        = cnt;
        mem_req_n    = mem_req;
        mem_addr_n   = mem_addr;
        ph0_n        = ph0;
        i_done_n     = 1'b0;
        c_done_n     = 1'b0;
        err_to_n     = err_to;

        case (state)
            IDLE: begin
                if (i_eff || c_eff) begin
                    if (i_eff && (!c_eff || last_grant == OWN_CACHE)) begin
                        owner_n    = OWN_INSTR;
                        mem_addr_n = i_addr;
                    end else begin
                        owner_n    = OWN_CACHE;
                        mem_addr_n = c_addr;
                    end
                    mem_req_n = 1'b1;
                    state_n   = MEM;
                end
            end
            MEM: begin
                if (mem_rdy) begin
                    mem_req_n = 1'b0;
                    ph0_n     = owner_code(owner);
                    cnt_n     = '0;
                    state_n   = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (owner_hab) begin
                    ph0_n   = PH0_NULL;
                    cnt_n   = '0;
                    state_n = WAIT_REL;
                end else if (timed_out) begin
                    // Abandon the transfer; the request stays pending for re-arbitration.
                    err_to_n     = 1'b1;
                    ph0_n        = PH0_NULL;
                    last_grant_n = owner;
                    state_n      = IDLE;
                end else begin
                    cnt_n = cnt + 8'd1;
                end
            end
            WAIT_REL: begin
                if (!owner_hab) begin
                    i_done_n     = (owner == OWN_INSTR);
                    c_done_n     = (owner == OWN_CACHE);
                    last_grant_n = owner;
                    state_n      = IDLE;
                end else if (timed_out) begin
                    err_to_n     = 1'b1;
                    ph0_n        = PH0_NULL;
                    last_grant_n = owner;
                    state_n      = IDLE;
                end else begin
                    cnt_n = cnt + 8'd1;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter with memory, demux-ack and requester models.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_req = 1'b0;
    logic [15:0] i_addr = '0;
    logic        c_req = 1'b0;
    logic [15:0] c_addr = '0;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_rdy = 1'b0;
    logic [1:0]  ph0;
    logic        hab_instr = 1'b0;
    logic        hab_cache = 1'b0;
    logic        i_done, c_done, err_to;

    mem_port_arbiter #(.ADDR_W(16), .SYNC_STAGES(2), .TIMEOUT(255)) dut (
        .clk       (clk),
        .rst       (rst),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .c_req     (c_req),
        .c_addr    (c_addr),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_rdy   (mem_rdy),
        .ph0       (ph0),
        .hab_instr (hab_instr),
        .hab_cache (hab_cache),
        .i_done    (i_done),
        .c_done    (c_done),
        .err_to    (err_to)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        is_instr;
        logic        abort;
        logic [15:0] addr;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   viol     = 0;

    logic [1:0] hi_pipe = '0, hc_pipe = '0;
    logic       force_i_en = 1'b0;
    logic       stuck_c = 1'b0;
    int         mcnt = 0;
    int         i_left = 0, c_left = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic is_instr, input logic abort, input logic [15:0] addr);
        exp_t e;
        e.is_instr = is_instr;
        e.abort    = abort;
        e.addr     = addr;
        exp_q.push_back(e);
    endtask

    // Memory answers a few cycles after mem_req; demux acks follow ph0 two cycles late;
    // requesters drop their level once the requested number of transfers has completed.
    always @(posedge clk) begin
        #1;
        mem_rdy = 1'b0;
        if (mem_req) begin
            mcnt++;
            if (mcnt == 3) mem_rdy = 1'b1;
        end else begin
            mcnt = 0;
        end
        hi_pipe   = {hi_pipe[0], ph0 == 2'b01};
        hc_pipe   = {hc_pipe[0], ph0 == 2'b10};
        hab_instr = force_i_en ? ~hab_instr : hi_pipe[1];
        hab_cache = stuck_c ? 1'b0 : hc_pipe[1];
        if (i_done && i_left > 0) begin
            i_left--;
            if (i_left == 0) i_req = 1'b0;
        end
        if (c_done && c_left > 0) begin
            c_left--;
            if (c_left == 0) c_req = 1'b0;
        end
    end

    logic        prev_req = 1'b0, prev_err = 1'b0;
    logic [15:0] seen_addr = '0;
    logic [1:0]  seen_ph0 = '0;

    // Monitor: every completion or abort is matched against the oldest expectation.
    always @(negedge clk) begin
        if (rst) begin
            prev_req = 1'b0;
            prev_err = 1'b0;
            seen_ph0 = '0;
        end else begin
            if (mem_req && !prev_req) begin
                seen_addr = mem_addr;
                seen_ph0  = '0;
            end
            if (ph0 != 2'b00) seen_ph0 = ph0;
            if (ph0 == 2'b11) viol++;
            if (i_done && c_done) viol++;
            if ((i_done || c_done) && mem_req) viol++;
            if (i_done || c_done || (err_to && !prev_err)) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("[TB] FAIL sb_unexpected: got event i_done=%b c_done=%b err_to=%b expected none at %0t",
                             i_done, c_done, err_to, $time);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("sb_abort", 32'(err_to && !prev_err), 32'(e.abort));
                    if (!e.abort) check("sb_done_instr", 32'(i_done), 32'(e.is_instr));
                    check("sb_ph0_route", 32'(seen_ph0), e.is_instr ? 32'h1 : 32'h2);
                    check("sb_addr", 32'(seen_addr), 32'(e.addr));
                    check("sb_ph0_null", 32'(ph0), 32'h0);
                end
            end
            prev_req = mem_req;
            prev_err = err_to;
        end
    end

    task automatic wait_drain(input string tag, input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge clk);
        check({"drain ", tag}, 32'(exp_q.size()), 32'h0);
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_ph0(input string tag, input logic [1:0] v, input int budget);
        int i;
        for (i = 0; i < budget && ph0 != v; i++) @(negedge clk);
        check({"wait_ph0 ", tag}, 32'(ph0), 32'(v));
    endtask

    task automatic check_reset(input string tag);
        check({tag, " mem_req"}, 32'(mem_req), 32'h0);
        check({tag, " mem_addr"}, 32'(mem_addr), 32'h0);
        check({tag, " ph0"}, 32'(ph0), 32'h0);
        check({tag, " i_done"}, 32'(i_done), 32'h0);
        check({tag, " c_done"}, 32'(c_done), 32'h0);
        check({tag, " err_to"}, 32'(err_to), 32'h0);
    endtask

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1 check_reset("reset");
        @(negedge clk) rst = 1'b0;

        // Simultaneous requests from reset: instr, cache, instr, cache.
        i_addr = 16'h1111;
        c_addr = 16'h2222;
        push(1'b1, 1'b0, 16'h1111);
        push(1'b0, 1'b0, 16'h2222);
        push(1'b1, 1'b0, 16'h1111);
        push(1'b0, 1'b0, 16'h2222);
        i_left = 2; c_left = 2;
        i_req = 1'b1; c_req = 1'b1;
        wait_drain("tie", 2000);

        // Single fetch.
        i_addr = 16'h0040;
        push(1'b1, 1'b0, 16'h0040);
        i_left = 1; i_req = 1'b1;
        wait_drain("fetch", 2000);

        // Cache transfer with the instr ack wiggling throughout.
        c_addr = 16'h3333;
        push(1'b0, 1'b0, 16'h3333);
        c_left = 1; c_req = 1'b1;
        force_i_en = 1'b1;
        wait_drain("hab_instr_noise", 2000);
        force_i_en = 1'b0;
        repeat (4) @(negedge clk);

        // Cache ack stuck low: abort, then instr wins, then cache retries.
        stuck_c = 1'b1;
        c_addr = 16'h4444;
        push(1'b0, 1'b1, 16'h4444);
        push(1'b1, 1'b0, 16'h5555);
        push(1'b0, 1'b0, 16'h4444);
        c_left = 1; c_req = 1'b1;
        wait_ph0("stuck", 2'b10, 100);
        i_addr = 16'h5555;
        i_left = 1; i_req = 1'b1;
        n = 0;
        while (!err_to && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("timeout_cycles", 32'(n), 32'd255);
        check("timeout_ph0", 32'(ph0), 32'h0);
        stuck_c = 1'b0;
        wait_drain("timeout", 2000);
        check("err_sticky", 32'(err_to), 32'h1);

        // Fetch request withdrawn while the read is outstanding.
        i_addr = 16'h6666;
        push(1'b1, 1'b0, 16'h6666);
        i_left = 1; i_req = 1'b1;
        for (int i = 0; i < 50 && !mem_req; i++) @(negedge clk);
        check("drop_mem_req", 32'(mem_req), 32'h1);
        i_req = 1'b0;
        wait_drain("drop", 2000);
        repeat (20) @(negedge clk);
        check("no_regrant", 32'(mem_req), 32'h0);

        // Reset while waiting for the cache ack.
        stuck_c = 1'b1;
        c_addr = 16'h7777;
        c_left = 1; c_req = 1'b1;
        wait_ph0("pre_rst", 2'b10, 100);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        c_req = 1'b0; c_left = 0; stuck_c = 1'b0;
        @(posedge clk);
        #1 check_reset("mid_rst");
        @(negedge clk) rst = 1'b0;

        i_addr = 16'h0088;
        push(1'b1, 1'b0, 16'h0088);
        i_left = 1; i_req = 1'b1;
        wait_drain("post_rst", 2000);

        check("invariants", 32'(viol), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
